// File: rtl/mdu_alu.sv
// Clocked EX-stage ALU with a registered single-cycle path and a
// multi-cycle shift-add multiplier / restoring divider writing HI/LO.
module mdu_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             div_zero
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MULT  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } state_t;

    state_t state, state_n;

    logic             accept;
    logic             is_multi;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             qneg;
    logic             rneg;

    assign accept   = start && (state == IDLE);
    assign is_multi = (op >= OP_MULT) && (op <= OP_DIVU);
    assign busy     = (state != IDLE);

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;

    assign shamt = reg_b[SHW-1:0];
    assign sum   = reg_a + reg_b;
    assign diff  = reg_a - reg_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (reg_a[WIDTH-1] == reg_b[WIDTH-1])
                       && (sum[WIDTH-1] != reg_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (reg_a[WIDTH-1] != reg_b[WIDTH-1])
                       && (diff[WIDTH-1] != reg_a[WIDTH-1]);
            end
            OP_AND:  alu_res = reg_a & reg_b;
            OP_OR:   alu_res = reg_a | reg_b;
            OP_XOR:  alu_res = reg_a ^ reg_b;
            OP_NOR:  alu_res = ~(reg_a | reg_b);
            OP_SLL:  alu_res = reg_a << shamt;
            OP_SRL:  alu_res = reg_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(reg_a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(reg_a) < $signed(reg_b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, reg_a < reg_b};
            default: alu_res = '0;
        endcase
    end

    // ---------------- multi-cycle datapath ----------------
    logic             is_div_q;
    logic             signed_q;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign is_div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign signed_q = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign a_neg    = signed_q && a_q[WIDTH-1];
    assign b_neg    = signed_q && b_q[WIDTH-1];
    assign a_abs    = a_neg ? -a_q : a_q;
    assign b_abs    = b_neg ? -b_q : b_q;

    // Multiply: acc = {partial, multiplier}, shifted right each step.
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH-1:0] mult_next;

    assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                     + (acc[0] ? {1'b0, mcand} : '0);
    assign mult_next = {upper_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;

    assign shifted  = acc[2*WIDTH-1:WIDTH-1];
    assign trial    = shifted - {1'b0, mcand};
    assign div_next = trial[WIDTH]
                    ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               dz;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_fix = qneg ? -acc : acc;
    assign quo_fix  = qneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign dz       = (b_q == '0);

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (dz) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept && is_multi) state_n = PREP;
            PREP:    state_n = ITER;
            ITER:    if (cnt == CNT_LAST) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            done     <= 1'b0;
            c        <= '0;
            hi       <= '0;
            lo       <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        a_q  <= reg_a;
                        b_q  <= reg_b;
                        if (!is_multi) begin
                            c        <= alu_res;
                            zero     <= (alu_res == '0);
                            negative <= alu_res[WIDTH-1];
                            overflow <= alu_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
                PREP: begin
                    mcand <= is_div_q ? b_abs : a_abs;
                    acc   <= {{WIDTH{1'b0}}, is_div_q ? a_abs : b_abs};
                    qneg  <= a_neg ^ b_neg;
                    rneg  <= a_neg;
                    cnt   <= '0;
                end
                ITER: begin
                    acc <= is_div_q ? div_next : mult_next;
                    cnt <= cnt + SHW'(1);
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    c        <= fix_lo;
                    zero     <= (fix_lo == '0);
                    negative <= fix_lo[WIDTH-1];
                    overflow <= 1'b0;
                    if (is_div_q) div_zero <= dz;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
